alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter: function
// encodings, response-register state and the requester ID type.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_func_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. control selects SUB for ADD and SRA for SRL;
// it is ignored for every other function. Shift amount is b[4:0].
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_func_t        func,
  input  logic             control,
  output logic [WIDTH-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    // NOTE: y gets a default before the case so no path can leave it unassigned and infer a latch.
    y = '0;
    case (func)
      ALU_ADD:  y = control ? (a - b) : (a + b);
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: y = WIDTH'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = control ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a registered, ID-tagged
// response and a saturating handshake counter. Define ALU_ARB_RR_EN for round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_func,
  input  logic             req0_control,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_func,
  input  logic             req1_control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t       state, state_next;
  req_id_t          grant, last_grant;
  logic             out_free, accept, consume;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  alu_func_t        alu_func;
  logic             alu_control;

  assign rsp_valid = (state == FULL);
  assign out_free  = !rsp_valid || rsp_ready;
  assign consume   = rsp_valid && rsp_ready;

  // Grant looks only at the valids and last_grant, never at the ALU output.
  always_comb begin
    grant = REQ0;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      grant = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (req1_valid) begin
      grant = REQ1;
    end
`else
    if (!req0_valid && req1_valid) begin
      grant = REQ1;
    end
`endif
  end

  assign req0_ready = out_free && (grant == REQ0);
  assign req1_ready = out_free && (grant == REQ1);
  assign accept     = (grant == REQ1) ? (req1_valid && req1_ready)
                                      : (req0_valid && req0_ready);

  assign alu_a       = (grant == REQ1) ? req1_a : req0_a;
  assign alu_b       = (grant == REQ1) ? req1_b : req0_b;
  assign alu_func    = alu_func_t'((grant == REQ1) ? req1_func : req0_func);
  assign alu_control = (grant == REQ1) ? req1_control : req0_control;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .func   (alu_func),
    .control(alu_control),
    .y      (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (consume && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // last_grant resets to REQ1 so requester 0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_id     <= REQ0;
      last_grant <= REQ1;
    end else if (accept) begin
      rsp_result <= alu_y;
      rsp_id     <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (consume && (op_count != CNT_MAX)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int W       = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_control;
  logic          req1_valid, req1_ready, req1_control;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_func, req1_func;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_result;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_func   (req0_func),
    .req0_control(req0_control),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_func   (req1_func),
    .req1_control(req1_control),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_id      (rsp_id),
    .op_count    (op_count)
  );

  typedef struct {
    logic         req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   func;
    logic         ctl;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one response slot, a count, the last winner.
  logic         m_valid;
  logic [W-1:0] m_result;
  logic         m_id;
  logic         m_last;
  int           m_count;
  int           last_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f, input logic c);
    int unsigned sh;
    sh = b[4:0];
    case (f)
      3'd0:    return c ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3:    return (a < b) ? 1 : 0;
      3'd4:    return a ^ b;
      3'd5:    return c ? W'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Which requester the model expects to be accepted this cycle (-1: none).
  function automatic int pick();
    if (m_valid && !rsp_ready) return -1;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      return (m_last == 1'b0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_result = '0;
    m_id     = 1'b0;
    m_last   = 1'b1;
    m_count  = 0;
    last_g   = -1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = 3'd0; req0_control = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = 3'd0; req1_control = 1'b0;
  endtask

  // Inputs are driven at posedge+1; readies checked at negedge, outputs at posedge+1.
  task automatic cycle();
    int           g;
    logic [W-1:0] res;
    @(negedge clk);
    g   = pick();
    res = (g == 1) ? ref_alu(req1_a, req1_b, req1_func, req1_control)
                   : ref_alu(req0_a, req0_b, req0_func, req0_control);
    check("hs0", 64'(req0_valid && req0_ready), 64'(g == 0));
    check("hs1", 64'(req1_valid && req1_ready), 64'(g == 1));
    if (m_valid && !rsp_ready) check("hold_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    if (m_valid && rsp_ready && m_count < CNT_MAX) m_count++;
    if (g >= 0) begin
      m_valid  = 1'b1;
      m_result = res;
      m_id     = g[0];
      m_last   = g[0];
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    check("rsp_valid", rsp_valid, m_valid);
    check("op_count", op_count, m_count);
    if (m_valid) begin
      check("rsp_result", rsp_result, m_result);
      check("rsp_id", rsp_id, m_id);
    end
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_count", op_count, 0);
    check("rst_result", rsp_result, 0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0001, 32'h0000_0001, 3'd0, 1'b0, 32'h0000_0002};
    vecs[1]  = '{1'b0, 32'h8000_00FF, 32'h0000_0010, 3'd5, 1'b1, 32'hFFFF_8000};
    vecs[2]  = '{1'b1, 32'h0000_0001, 32'h0000_0000, 3'd0, 1'b1, 32'h0000_0001};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 32'h0000_0001};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0001, 32'h0000_001F, 3'd1, 1'b0, 32'h8000_0000};
    vecs[7]  = '{1'b0, 32'h8000_00FF, 32'h0000_0010, 3'd5, 1'b0, 32'h0000_8000};
    vecs[8]  = '{1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 1'b0, 32'hFF00_FF00};
    vecs[9]  = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 1'b0, 32'hFFF0_FFF0};
    vecs[10] = '{1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd7, 1'b0, 32'h00F0_00F0};
    vecs[11] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 3'd0, 1'b1, 32'hFFFF_FFFE};
    vecs[12] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 3'd4, 1'b1, 32'h0000_0006};

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_valid", rsp_valid, 0);
    check("reset_result", rsp_result, 0);
    check("reset_id", rsp_id, 0);
    check("reset_count", op_count, 0);

    // Single requester: 1+1 on req0, then one consume cycle.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_func = 3'd0; req0_control = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    check("single_result", rsp_result, 32'h0000_0002);
    check("single_id", rsp_id, 0);
    idle();
    cycle();
    check("single_count", op_count, 1);

    // Directed vector table, one request per cycle, back-to-back.
    foreach (vecs[i]) begin
      idle();
      if (vecs[i].req) begin
        req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
        req1_func = vecs[i].func; req1_control = vecs[i].ctl;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
        req0_func = vecs[i].func; req0_control = vecs[i].ctl;
      end
      rsp_ready = 1'b1;
      cycle();
      check("vec_result", rsp_result, vecs[i].exp);
      check("vec_id", rsp_id, vecs[i].req);
    end
    idle();
    cycle();

    // Reset asserted while a result is pending.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4;
    rsp_ready = 1'b0;
    cycle();
    check("pre_rst_valid", rsp_valid, 1);
    do_reset();

    // Contention: both valid each cycle.
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
`ifdef ALU_ARB_RR_EN
      check("cont_id", rsp_id, i % 2);
`else
      check("cont_id", rsp_id, 0);
`endif
    end

    // Backpressure: req1 result held while the consumer stalls.
    do_reset();
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_func = 3'd0;
    rsp_ready = 1'b0;
    cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_result", rsp_result, 32'h0000_0000);
      check("bp_id", rsp_id, 1);
    end
    check("bp_count_before", op_count, 0);
    rsp_ready = 1'b1;
    cycle();
    check("bp_count_after", op_count, 1);

    // Counter saturation: 20 response handshakes into a 4-bit counter.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1;
    rsp_ready = 1'b1;
    repeat (21) cycle();
    check("sat_count", op_count, 4'hF);

    // Randomized traffic; a stalled request keeps its operands.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || last_g == 0) begin
        req0_valid   = ($urandom_range(0, 9) < 7);
        req0_a       = (i % 3 == 0) ? 32'h8000_0000 | $urandom : $urandom;
        req0_b       = $urandom;
        req0_func    = 3'($urandom_range(0, 7));
        req0_control = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || last_g == 1) begin
        req1_valid   = ($urandom_range(0, 9) < 7);
        req1_a       = $urandom;
        req1_b       = (i % 4 == 0) ? req1_a : $urandom;
        req1_func    = 3'($urandom_range(0, 7));
        req1_control = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
